// File: rtl/gene_line_decompress_if.sv
// Packed-line input and ASCII beat output streams
// for the gene line decompressor.
interface gene_line_decompress_if #(
  parameter int LINE_CHARS     = 100,
  parameter int CHARS_PER_BEAT = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic [2*LINE_CHARS-1:0]     in_line;
  logic                        out_valid;
  logic                        out_ready;
  logic [8*CHARS_PER_BEAT-1:0] out_data;
  logic                        out_last;

  modport master (
    output in_valid,
    output in_line,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_line,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last
  );
endinterface

// File: rtl/gene_line_decompress.sv
// Unpacks one line of 2-bit nucleotide codes and
// streams it out as ASCII, CHARS_PER_BEAT per beat.
module gene_line_decompress #(
  parameter int LINE_CHARS     = 100,
  parameter int CHARS_PER_BEAT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gene_line_decompress_if.slave   bus,
  output logic                    busy
);
  localparam int BEATS  = LINE_CHARS / CHARS_PER_BEAT;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LINE_W = 2 * LINE_CHARS;
  localparam int BEAT_W = 2 * CHARS_PER_BEAT;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    beatCnt;
  logic [LINE_W-1:0]   shiftReg;
  logic                emitting;
  logic                lastBeat;
  logic                beatFire;
  logic                lineTake;
  logic [8*CHARS_PER_BEAT-1:0] ascii;

  assign emitting = (state == EMIT);
  assign lastBeat = emitting &&
                    (beatCnt == CNT_W'(BEATS - 1));
  assign beatFire = emitting && bus.out_ready;

  // A new line may load on the final handshake,
  // keeping the output stream bubble-free.
  assign bus.in_ready = (state == IDLE) ||
                        (beatFire && lastBeat);
  assign lineTake = bus.in_valid && bus.in_ready;

  assign bus.out_valid = emitting;
  assign bus.out_last  = lastBeat;
  assign bus.out_data  = emitting ? ascii : '0;
  assign busy          = emitting;

  // Decode the top codes of the shift register.
  always_comb begin
    ascii = '0;
    for (int i = 0; i < CHARS_PER_BEAT; i++) begin
      unique case (shiftReg[LINE_W-1-2*i -: 2])
        2'b00: ascii[8*CHARS_PER_BEAT-1-8*i -: 8] = 8'h41;
        2'b01: ascii[8*CHARS_PER_BEAT-1-8*i -: 8] = 8'h43;
        2'b10: ascii[8*CHARS_PER_BEAT-1-8*i -: 8] = 8'h47;
        2'b11: ascii[8*CHARS_PER_BEAT-1-8*i -: 8] = 8'h54;
      endcase
    end
  end

  // Line load, beat advance and end-of-line return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beatCnt  <= '0;
      shiftReg <= '0;
    end else if (lineTake) begin
      state    <= EMIT;
      beatCnt  <= '0;
      shiftReg <= bus.in_line;
    end else if (beatFire) begin
      if (lastBeat) begin
        state    <= IDLE;
        beatCnt  <= '0;
        shiftReg <= '0;
      end else begin
        beatCnt  <= beatCnt + CNT_W'(1);
        shiftReg <= shiftReg << BEAT_W;
      end
    end
  end
endmodule

// File: tb/tb_gene_line_decompress.sv
// Scoreboard bench for gene_line_decompress:
// stimulus queues expected beats, a monitor checks them.
module tb_gene_line_decompress;
  localparam int LC  = 100;
  localparam int CPB = 4;
  localparam int NB  = LC / CPB;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk;
  logic rst_n;
  logic busy;
  int   errors;
  int   checks;
  int   hsCount;
  bit   rndMode;
  exp_t q[$];

  gene_line_decompress_if #(
    .LINE_CHARS(LC),
    .CHARS_PER_BEAT(CPB)
  ) bus ();

  gene_line_decompress #(
    .LINE_CHARS(LC),
    .CHARS_PER_BEAT(CPB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // out_ready driver: steady high or pseudo-random
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rndMode)
        bus.out_ready = 1'($urandom_range(0, 1));
      else
        bus.out_ready = 1'b1;
    end
  end

  // Monitor: compare presented beats with queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL extraBeat data=%h last=%b expected none",
                   bus.out_data, bus.out_last);
        end else begin
          e = q[0];
          if (bus.out_data !== e.data ||
              bus.out_last !== e.last) begin
            errors++;
            $display("FAIL beat got=%h/%b exp=%h/%b",
                     bus.out_data, bus.out_last,
                     e.data, e.last);
          end
          if (bus.out_ready) begin
            void'(q.pop_front());
            hsCount++;
          end
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] code(input byte ch);
    case (ch)
      "A":     return 2'b00;
      "C":     return 2'b01;
      "G":     return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [2*LC-1:0] packStr(input string b);
    logic [2*LC-1:0] l;
    l = '0;
    for (int i = 0; i < LC; i++)
      l[2*LC-1-2*i -: 2] = code(b[i % b.len()]);
    return l;
  endfunction

  task automatic pushConst(input logic [31:0] d);
    for (int j = 0; j < NB; j++)
      q.push_back('{data: d, last: (j == NB - 1)});
  endtask

  task automatic pushStr(input string b);
    logic [31:0] d;
    for (int j = 0; j < NB; j++) begin
      for (int k = 0; k < CPB; k++)
        d[31-8*k -: 8] = b[(CPB*j + k) % b.len()];
      q.push_back('{data: d, last: (j == NB - 1)});
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after accept
  task automatic sendLine(input logic [2*LC-1:0] l);
    bus.in_line  = l;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    chk("acceptTimeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0) return;
    end
    chk("drainTimeout", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int base;
    int bad;
    errors       = 0;
    checks       = 0;
    hsCount      = 0;
    rndMode      = 1'b0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_line  = '0;
    #1;
    chk("rstOutValid", 64'(bus.out_valid), 64'd0);
    chk("rstOutLast", 64'(bus.out_last), 64'd0);
    chk("rstOutData", 64'(bus.out_data), 64'd0);
    chk("rstInReady", 64'(bus.in_ready), 64'd1);
    chk("rstBusy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: all 'A'
    base = hsCount;
    pushConst(32'h41414141);
    sendLine('0);
    chk("t1BusyAfterLoad", 64'(busy), 64'd1);
    waitDrain(100);
    chk("t1Beats", 64'(hsCount - base), 64'd25);
    chk("t1InReady", 64'(bus.in_ready), 64'd1);
    chk("t1Busy", 64'(busy), 64'd0);
    chk("t1OutValid", 64'(bus.out_valid), 64'd0);

    // 2: "ACGT" repeated
    base = hsCount;
    pushConst(32'h41434754);
    sendLine({25{8'h1B}});
    waitDrain(100);
    chk("t2Beats", 64'(hsCount - base), 64'd25);

    // 3: same line under random backpressure
    rndMode = 1'b1;
    base = hsCount;
    pushConst(32'h41434754);
    sendLine({25{8'h1B}});
    waitDrain(400);
    rndMode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t3Beats", 64'(hsCount - base), 64'd25);
    chk("t3Idle", 64'(bus.out_valid), 64'd0);

    // 4: back-to-back lines, no bubble
    base = hsCount;
    bad = 0;
    pushConst(32'h41414141);
    sendLine('0);
    pushConst(32'h54545454);
    fork
      sendLine('1);
      begin
        for (int c = 0; c < 2 * NB; c++) begin
          @(negedge clk);
          if (!bus.out_valid) bad++;
        end
      end
    join
    chk("t4Bubbles", 64'(bad), 64'd0);
    waitDrain(20);
    chk("t4Beats", 64'(hsCount - base), 64'd50);
    chk("t4Busy", 64'(busy), 64'd0);

    // 5: reset mid-line
    base = hsCount;
    pushStr("GATTACACGT");
    sendLine(packStr("GATTACACGT"));
    for (int c = 0; c < 50; c++) begin
      if (hsCount - base >= 9) break;
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("t5RstValid", 64'(bus.out_valid), 64'd0);
    chk("t5RstData", 64'(bus.out_data), 64'd0);
    chk("t5RstLast", 64'(bus.out_last), 64'd0);
    chk("t5RstBusy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t5InReady", 64'(bus.in_ready), 64'd1);
    base = hsCount;
    pushStr("GATTACACGT");
    sendLine(packStr("GATTACACGT"));
    waitDrain(100);
    chk("t5Beats", 64'(hsCount - base), 64'd25);

    // 6: round trip of a packed "CCCC.." string
    base = hsCount;
    pushConst(32'h43434343);
    sendLine(packStr("C"));
    waitDrain(100);
    chk("t6Beats", 64'(hsCount - base), 64'd25);
    chk("t6InReady", 64'(bus.in_ready), 64'd1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
